// File: rtl/axis_arb_pkg.sv
// Shared types and widths for the packet-granular AXI-Stream arbiter.
package axis_arb_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [IW-1:0] p;
        found = 1'b0;
        idx   = '0;
        p     = '0;
        for (int k = N; k >= 1; k--) begin
            p = IW'((int'(last) + k) % N);
            if (req[p]) begin
                found = 1'b1;
                idx   = p;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-wide AXI-Stream sink
// between N_PORTS sources. Oversize packets are cut at MAX_PKT_LEN with a
// forced tlast and the remainder of the input packet is discarded.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int MAX_PKT_LEN = 1518,
    localparam int IDX_W      = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          in_tvalid,
    output logic [N_PORTS-1:0]          in_tready,
    input  logic [BYTE_W*N_PORTS-1:0]   in_tdata,
    input  logic [N_PORTS-1:0]          in_tlast,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic [BYTE_W-1:0]           out_tdata,
    output logic                        out_tlast,
    output logic                        grant_vld,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        trunc_pulse
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);

    arb_state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_grant, r_last;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out_vld, r_out_last, r_trunc;
    logic [BYTE_W-1:0]      r_out_data;

    logic                   w_pick_found;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [BYTE_W-1:0]      w_bytes [N_PORTS];
    logic                   w_slot_free, w_sel_vld, w_sel_last, w_at_max;
    logic                   w_accept, w_load;
    logic [N_PORTS-1:0]     w_in_tready;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_bytes
        assign w_bytes[i] = in_tdata[BYTE_W*i +: BYTE_W];
    end

    rr_pick #(.N(N_PORTS)) u_pick (
        .req   (in_tvalid),
        .last  (r_last),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    assign w_slot_free = !r_out_vld || out_tready;
    assign w_sel_vld   = in_tvalid[r_grant];
    assign w_sel_last  = in_tlast[r_grant];
    assign w_at_max    = (r_cnt == LAST_CNT);

    // Next state, per-port ready and beat acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_in_tready = '0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) w_state_nxt = PASS;
            end
            PASS: begin
                w_in_tready[r_grant] = w_slot_free;
                w_accept             = w_sel_vld && w_slot_free;
                w_load               = w_accept;
                if (w_accept) begin
                    if (w_sel_last)    w_state_nxt = IDLE;
                    else if (w_at_max) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Discard the tail at full rate; the sink is not involved.
                w_in_tready[r_grant] = 1'b1;
                w_accept             = w_sel_vld;
                if (w_accept && w_sel_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Grant, last-served port and per-packet byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_last  <= IDX_W'(N_PORTS - 1);
            r_cnt   <= '0;
        end else begin
            if (r_state == IDLE && w_pick_found) begin
                r_grant <= w_pick_idx;
                r_cnt   <= '0;
            end
            if (r_state == PASS && w_accept) r_cnt <= r_cnt + 1'b1;
            if (w_accept && w_sel_last)     r_last <= r_grant;
        end
    end

    // Output register: load on accepted PASS beat, else drain on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_trunc    <= 1'b0;
        end else begin
            r_trunc <= w_load && !w_sel_last && w_at_max;
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_bytes[r_grant];
                r_out_last <= w_sel_last || w_at_max;
            end else if (out_tready) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    assign in_tready   = w_in_tready;
    assign out_tvalid  = r_out_vld;
    assign out_tdata   = r_out_data;
    assign out_tlast   = r_out_last;
    assign grant_vld   = (r_state != IDLE);
    assign grant_idx   = r_grant;
    assign trunc_pulse = r_trunc;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomized bench with a packet-level reference model for axis_pkt_arbiter.
module tb_axis_pkt_arbiter;

    localparam int NP  = 4;
    localparam int MAX = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   in_tvalid = '0;
    logic [NP-1:0]   in_tready;
    logic [8*NP-1:0] in_tdata = '0;
    logic [NP-1:0]   in_tlast = '0;
    logic            out_tvalid;
    logic            out_tready = 1'b1;
    logic [7:0]      out_tdata;
    logic            out_tlast;
    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic            trunc_pulse;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.N_PORTS(NP), .MAX_PKT_LEN(MAX)) dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .grant_vld(grant_vld), .grant_idx(grant_idx), .trunc_pulse(trunc_pulse)
    );

    typedef struct { logic [7:0] d; logic l; } beat_t;

    beat_t      dq[NP][$];      // driver beats per port
    logic [7:0] mb[NP][$];      // model: bytes per port
    int         ml[NP][$];      // model: packet lengths per port
    beat_t      exp_q[$];       // expected output beats
    beat_t      out_log[$];
    int         grant_log[$];
    int         tp_cnt = 0;
    int         n_chk = 0, n_fail = 0;
    int         vprob = 100, rmode = 0;

    int            m_last = NP-1, m_gidx = 0, acc = 0;
    bit            in_pkt = 0, exp_tp = 0;
    logic [NP-1:0] hs = '0, p_tv = '0;
    bit            p_ov = 0, p_ordy = 0, p_gv = 0, p_ol = 0;
    logic [7:0]    p_od = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Round-robin rule: first requester after the last finished port.
    function automatic int rr_expect(input logic [NP-1:0] req, input int last);
        for (int k = 1; k <= NP; k++)
            if (req[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    // base < 0 -> random bytes, else base, base+1, ...
    task automatic add_pkt(input int port, input int len, input int base);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + j);
            b.l = (j == len - 1);
            dq[port].push_back(b);
            mb[port].push_back(b.d);
        end
        ml[port].push_back(len);
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            dq[p].delete(); mb[p].delete(); ml[p].delete();
        end
        exp_q.delete();
    endtask

    task automatic clear_logs();
        out_log.delete();
        grant_log.delete();
    endtask

    task automatic drive();
        beat_t b;
        if (rst) begin
            in_tvalid = '0; in_tlast = '0; in_tdata = '0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (hs[i]) begin
                    b = dq[i].pop_front();
                    in_tvalid[i] = 1'b0;
                end
                if (!in_tvalid[i] && dq[i].size() > 0 && $urandom_range(0, 99) < vprob)
                    in_tvalid[i] = 1'b1;
                if (in_tvalid[i]) begin
                    in_tdata[8*i +: 8] = dq[i][0].d;
                    in_tlast[i]        = dq[i][0].l;
                end
            end
        end
        hs = '0;
        case (rmode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            2:       out_tready = 1'($urandom_range(0, 1));
            default: out_tready = 1'b0;
        endcase
    endtask

    task automatic monitor();
        int            e, len;
        beat_t         b;
        logic [7:0]    d;
        logic [NP-1:0] exp_rdy;
        if (rst) begin
            m_last = NP-1; m_gidx = 0; in_pkt = 0; acc = 0; exp_tp = 0;
            hs = '0; p_tv = '0; p_ov = 0; p_ordy = 0; p_gv = 0;
            exp_q.delete();
            return;
        end
        if (p_ov && !p_ordy) begin
            chk("hold_tvalid", out_tvalid, 1);
            chk("hold_tdata", out_tdata, p_od);
            chk("hold_tlast", out_tlast, p_ol);
        end
        if (grant_vld && !p_gv) begin
            e = rr_expect(p_tv, m_last);
            chk("arb_idx", grant_idx, e);
            m_gidx = (e < 0) ? int'(grant_idx) : e;
            grant_log.push_back(m_gidx);
            in_pkt = 1; acc = 0;
            if (ml[m_gidx].size() == 0) fail("grant_without_packet");
            else begin
                len = ml[m_gidx].pop_front();
                for (int j = 0; j < len; j++) begin
                    d = mb[m_gidx].pop_front();
                    if (j < MAX) begin
                        b.d = d;
                        b.l = (j == len - 1) || (j == MAX - 1);
                        exp_q.push_back(b);
                    end
                end
            end
        end
        chk("grant_vld", grant_vld, in_pkt);
        chk("grant_idx", grant_idx, m_gidx);
        exp_rdy = '0;
        if (in_pkt) exp_rdy[m_gidx] = (acc < MAX) ? (!out_tvalid || out_tready) : 1'b1;
        chk("in_tready", in_tready, exp_rdy);
        chk("trunc_pulse", trunc_pulse, exp_tp);
        if (trunc_pulse) tp_cnt++;
        exp_tp = 0;
        if (out_tvalid && out_tready) begin
            b.d = out_tdata; b.l = out_tlast;
            out_log.push_back(b);
            if (exp_q.size() == 0) fail("unexpected_output_beat");
            else begin
                b = exp_q.pop_front();
                chk("out_tdata", out_tdata, b.d);
                chk("out_tlast", out_tlast, b.l);
            end
        end
        hs = in_tvalid & in_tready;
        if (in_pkt && hs[m_gidx]) begin
            acc++;
            if (in_tlast[m_gidx]) begin
                in_pkt = 0; m_last = m_gidx;
            end else if (acc == MAX) exp_tp = 1;
        end
        p_ov = out_tvalid; p_ordy = out_tready; p_od = out_tdata; p_ol = out_tlast;
        p_gv = grant_vld; p_tv = in_tvalid;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            drive();
            @(negedge clk);
            monitor();
        end
    end

    function automatic bit all_done();
        for (int p = 0; p < NP; p++)
            if (dq[p].size() != 0 || ml[p].size() != 0) return 0;
        return exp_q.size() == 0 && !in_pkt && !grant_vld && !out_tvalid;
    endfunction

    task automatic wait_done(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk); #1;
            done = all_done();
        end
        if (!done) fail("timeout_waiting_for_drain");
    endtask

    task automatic reset_dut();
        @(negedge clk); #2;
        rst = 1'b1;
        flush();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int k, input int d, input int l);
        if (k >= out_log.size()) fail({nm, "_missing"});
        else begin
            chk({nm, "_data"}, out_log[k].d, d);
            chk({nm, "_last"}, out_log[k].l, l);
        end
    endtask

    task automatic chk_grant(input string nm, input int k, input int g);
        if (k >= grant_log.size()) fail({nm, "_missing"});
        else chk(nm, grant_log[k], g);
    endtask

    initial begin
        int n, tp0, ntr;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_out_tdata", out_tdata, 0);
        chk("rst_out_tlast", out_tlast, 0);
        chk("rst_grant_vld", grant_vld, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_trunc", trunc_pulse, 0);
        chk("rst_in_tready", in_tready, 0);
        #1 rst = 1'b0;

        // 1: single 3-byte packet on port 0, one arbitration bubble
        clear_logs();
        add_pkt(0, 3, 'hA1);
        n = 0;
        while (!in_tvalid[0] && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!out_tvalid && n < 20) begin @(negedge clk); n++; end
        chk("t1_latency", n, 2);
        wait_done(200);
        chk("t1_count", out_log.size(), 3);
        chk_out("t1_b0", 0, 'hA1, 0);
        chk_out("t1_b1", 1, 'hA2, 0);
        chk_out("t1_b2", 2, 'hA3, 1);
        chk_grant("t1_grant", 0, 0);

        // 2: all ports with back-to-back 2-byte packets
        reset_dut();
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 2, 16*p + 8*r);
        wait_done(500);
        chk_grant("t2_g0", 0, 0);
        chk_grant("t2_g1", 1, 1);
        chk_grant("t2_g2", 2, 2);
        chk_grant("t2_g3", 3, 3);
        chk_grant("t2_g4", 4, 0);
        chk("t2_count", out_log.size(), 16);
        for (int k = 0; k < out_log.size(); k++) chk("t2_last_pattern", out_log[k].l, k % 2);

        // 3: port 1 streaming against a toggling sink
        rmode = 1;
        clear_logs();
        add_pkt(1, 3, 'h10);
        add_pkt(1, 3, 'h20);
        wait_done(500);
        chk("t3_count", out_log.size(), 6);
        chk_out("t3_b0", 0, 'h10, 0);
        chk_out("t3_b2", 2, 'h12, 1);
        chk_out("t3_b3", 3, 'h20, 0);
        chk_out("t3_b5", 5, 'h22, 1);

        // 4: 7-byte packet on port 2 truncated at 4, then port 0 served
        clear_logs();
        tp0 = tp_cnt;
        add_pkt(2, 7, 'h30);
        add_pkt(0, 2, 'h40);
        wait_done(500);
        chk_grant("t4_g0", 0, 2);
        chk_grant("t4_g1", 1, 0);
        chk("t4_count", out_log.size(), 6);
        chk_out("t4_b2", 2, 'h32, 0);
        chk_out("t4_b3", 3, 'h33, 1);
        chk_out("t4_b4", 4, 'h40, 0);
        chk_out("t4_b5", 5, 'h41, 1);
        chk("t4_trunc_count", tp_cnt - tp0, 1);

        // 5: tlast exactly at MAX is a natural end
        rmode = 0;
        clear_logs();
        tp0 = tp_cnt;
        add_pkt(1, 4, 'h50);
        wait_done(500);
        chk("t5_count", out_log.size(), 4);
        chk_out("t5_b3", 3, 'h53, 1);
        chk_out("t5_b2", 2, 'h52, 0);
        chk("t5_trunc_count", tp_cnt - tp0, 0);

        // 6: reset mid-packet on port 3
        rmode = 3;
        add_pkt(3, 6, 'h90);
        n = 0;
        while (!(grant_vld && grant_idx == 2'd3 && out_tvalid) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail("t6_no_midpacket");
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_out_tvalid", out_tvalid, 0);
        chk("t6_out_tdata", out_tdata, 0);
        chk("t6_out_tlast", out_tlast, 0);
        chk("t6_grant_vld", grant_vld, 0);
        chk("t6_grant_idx", grant_idx, 0);
        chk("t6_in_tready", in_tready, 0);
        chk("t6_trunc", trunc_pulse, 0);
        flush();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        rmode = 0;
        clear_logs();
        add_pkt(3, 2, 'h60);
        add_pkt(1, 2, 'h70);
        add_pkt(0, 2, 'h80);
        wait_done(500);
        chk_grant("t6_g0", 0, 0);
        chk_grant("t6_g1", 1, 1);
        chk_grant("t6_g2", 2, 3);
        chk_out("t6_b0", 0, 'h80, 0);

        // Random traffic: gaps on sources, random sink backpressure
        rmode = 2;
        vprob = 60;
        tp0 = tp_cnt;
        ntr = 0;
        for (int k = 0; k < 150; k++) begin
            n = $urandom_range(1, 7);
            if (n > MAX) ntr++;
            add_pkt($urandom_range(0, NP-1), n, -1);
        end
        wait_done(20000);
        chk("rand_trunc_count", tp_cnt - tp0, ntr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
